// File: rtl/cnn_act_stream.sv
// cnn_act_stream
// Streaming activation stage between the accumulator output and pooling/writeback.
// Each beat carries LANES signed elements. The selected activation is applied when
// the beat is accepted, and the result is held in a small FIFO until downstream
// takes it. A saturating counter tracks how many negative elements were zeroed.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in_data/valid   upstream beat, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready        high whenever the FIFO is not full (registered state only)
//   out_data/valid  FIFO head and non-empty flag
//   out_ready       downstream accepts the head beat
//   cfg_mode        0 bypass, 1 ReLU, 2 clipped ReLU, 3 leaky ReLU (arithmetic shift)
//   cfg_clip        signed upper bound for mode 2 (negative values act as 0)
//   cfg_shift       right-shift amount applied to negative inputs in mode 3
//   cnt_clr         synchronous clear of zero_count, wins over any increment
//   zero_count      saturating count of negative elements zeroed in modes 1/2
//   fifo_level      current FIFO occupancy
module cnn_act_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic [1:0]                    cfg_mode,
    input  logic [DATA_WIDTH-1:0]         cfg_clip,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cnt_clr,
    output logic [31:0]                   zero_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(LANES + 1);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_CLIP   = 2'd2,
        MODE_LEAKY  = 2'd3
    } actMode_e;

    logic [LANES*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]               rdPtr_q, rdPtr_d;
    logic [AW-1:0]               wrPtr_q, wrPtr_d;
    logic [AW:0]                 level_q, level_d;
    logic [31:0]                 zeroCount_q, zeroCount_d;

    logic [LANES*DATA_WIDTH-1:0] actData;
    logic [CW-1:0]               negLanes;
    logic signed [DATA_WIDTH-1:0] laneX, laneY, clipVal;
    logic [32:0]                 countSum;
    logic                        push, pop;
    actMode_e                    mode;

    assign mode       = actMode_e'(cfg_mode);
    assign in_ready   = (level_q != FULL_LEVEL);
    assign out_valid  = (level_q != '0);
    assign out_data   = mem_q[rdPtr_q];
    assign fifo_level = level_q;
    assign zero_count = zeroCount_q;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // Per-lane activation of the incoming beat. A negative clip bound collapses
    // to zero so mode 2 never produces a negative result. negLanes counts only
    // inputs that were negative in the zeroing modes; lanes forced to zero by a
    // zero clip bound are not counted.
    always_comb begin
        actData  = '0;
        negLanes = '0;
        laneX    = '0;
        laneY    = '0;
        clipVal  = cfg_clip[DATA_WIDTH-1] ? '0 : $signed(cfg_clip);
        for (int i = 0; i < LANES; i++) begin
            laneX = $signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
            case (mode)
                MODE_RELU:  laneY = laneX[DATA_WIDTH-1] ? '0 : laneX;
                MODE_CLIP: begin
                    if (laneX[DATA_WIDTH-1])  laneY = '0;
                    else if (laneX > clipVal) laneY = clipVal;
                    else                      laneY = laneX;
                end
                MODE_LEAKY: laneY = laneX[DATA_WIDTH-1] ? (laneX >>> cfg_shift) : laneX;
                default:    laneY = laneX;
            endcase
            actData[i*DATA_WIDTH +: DATA_WIDTH] = laneY;
            if ((mode == MODE_RELU || mode == MODE_CLIP) && laneX[DATA_WIDTH-1]) begin
                negLanes = negLanes + CW'(1);
            end
        end
    end

    // Next-state for pointers, occupancy and the zero counter. The counter adds
    // in 33 bits so the carry out signals saturation; clear always wins.
    always_comb begin
        rdPtr_d     = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        wrPtr_d     = push ? wrPtr_q + 1'b1 : wrPtr_q;
        level_d     = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;

        countSum    = {1'b0, zeroCount_q} + {{(33-CW){1'b0}}, negLanes};
        zeroCount_d = zeroCount_q;
        if (cnt_clr)   zeroCount_d = '0;
        else if (push) zeroCount_d = countSum[32] ? '1 : countSum[31:0];
    end

    // State registers. Reset flushes every buffered beat at once so nothing
    // stale can be emitted after reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            level_q     <= '0;
            zeroCount_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            level_q     <= level_d;
            zeroCount_q <= zeroCount_d;
            if (push) begin
                mem_q[wrPtr_q] <= actData;
            end
        end
    end

endmodule

// File: tb/tb_cnn_act_stream.sv
// tb_cnn_act_stream
// Directed bench for cnn_act_stream. A queue-based reference model tracks which
// activated beats must be buffered and what the zero counter must read; a compare
// process checks every output against it on each falling edge. Literal expectations
// at key points pin the model to hand-computed values.
module tb_cnn_act_stream;

    localparam int DW    = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic [127:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       cfg_mode;
    logic [31:0]      cfg_clip;
    logic [4:0]       cfg_shift;
    logic             cnt_clr;
    logic [31:0]      zero_count;
    logic [1:0]       fifo_level;

    int totalChecks = 0;
    int badChecks   = 0;
    int popsSeen    = 0;

    logic [127:0] mq[$];
    longint       zcModel;

    cnn_act_stream #(
        .DATA_WIDTH (DW),
        .LANES      (LANES),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cfg_mode   (cfg_mode),
        .cfg_clip   (cfg_clip),
        .cfg_shift  (cfg_shift),
        .cnt_clr    (cnt_clr),
        .zero_count (zero_count),
        .fifo_level (fifo_level)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison; mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] packLanes(input int l0, input int l1, input int l2, input int l3);
        return {l3, l2, l1, l0};
    endfunction

    // Activation rule per element, straight from the mode definitions.
    function automatic int actModel(input int x, input int mode, input int clip, input int sh);
        int c;
        c = (clip < 0) ? 0 : clip;
        case (mode)
            1:       return (x < 0) ? 0 : x;
            2:       return (x < 0) ? 0 : ((x < c) ? x : c);
            3:       return (x < 0) ? (x >>> sh) : x;
            default: return x;
        endcase
    endfunction

    // Reference model: queue of expected beats plus the expected counter value.
    always @(posedge clk or negedge rst_n) begin : refModel
        logic [127:0] beat;
        bit           acc, pp;
        int           nNeg, x;
        if (!rst_n) begin
            mq.delete();
            zcModel = 0;
        end else begin
            acc  = in_valid && (mq.size() < DEPTH);
            pp   = out_ready && (mq.size() > 0);
            nNeg = 0;
            beat = '0;
            for (int i = 0; i < LANES; i++) begin
                x = $signed(in_data[i*32 +: 32]);
                beat[i*32 +: 32] = actModel(x, int'(cfg_mode), $signed(cfg_clip), int'(cfg_shift));
                if ((cfg_mode == 2'd1 || cfg_mode == 2'd2) && x < 0) nNeg++;
            end
            if (pp)  void'(mq.pop_front());
            if (acc) mq.push_back(beat);
            if (cnt_clr)  zcModel = 0;
            else if (acc) zcModel = (zcModel + nNeg > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : zcModel + nNeg;
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("in_ready",   {127'd0, in_ready},   {127'd0, mq.size() < DEPTH});
        checkOutput("out_valid",  {127'd0, out_valid},  {127'd0, mq.size() > 0});
        checkOutput("fifo_level", {126'd0, fifo_level}, 128'(mq.size()));
        checkOutput("zero_count", {96'd0, zero_count},  {96'd0, zcModel[31:0]});
        if (mq.size() > 0) checkOutput("out_data", out_data, mq[0]);
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) popsSeen++;
    end

    // Present one beat and hold it until it is accepted.
    task automatic applyStimulus(input logic [127:0] data, input logic [1:0] mode,
                                 input int clip, input int sh, input logic clr);
        int guard;
        @(negedge clk);
        in_data   = data;
        cfg_mode  = mode;
        cfg_clip  = clip;
        cfg_shift = sh[4:0];
        cnt_clr   = clr;
        in_valid  = 1'b1;
        guard     = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cfg_mode  = 2'd0;
        cfg_clip  = '0;
        cfg_shift = '0;
        cnt_clr   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready",   {127'd0, in_ready},   128'd1);
        checkOutput("rst_out_valid",  {127'd0, out_valid},  128'd0);
        checkOutput("rst_out_data",   out_data,             128'd0);
        checkOutput("rst_zero_count", {96'd0, zero_count},  128'd0);
        checkOutput("rst_fifo_level", {126'd0, fifo_level}, 128'd0);
        #2 rst_n = 1'b1;
        idle(2);

        // ReLU, one-cycle latency
        applyStimulus(packLanes(-5, 0, 7, 32'h8000_0000), 2'd1, 0, 0, 1'b0);
        #1;
        checkOutput("relu_valid", {127'd0, out_valid}, 128'd1);
        checkOutput("relu_data",  out_data, packLanes(0, 0, 7, 0));
        checkOutput("relu_count", {96'd0, zero_count}, 128'd2);

        // Clipped ReLU with positive and negative bound
        applyStimulus(packLanes(3, 6, 9, -1), 2'd2, 6, 0, 1'b0);
        #1 checkOutput("clip6_data", out_data, packLanes(3, 6, 6, 0));
        applyStimulus(packLanes(3, -2, 0, 8), 2'd2, -4, 0, 1'b0);
        #1;
        checkOutput("clipneg_data",  out_data, packLanes(0, 0, 0, 0));
        checkOutput("clipneg_count", {96'd0, zero_count}, 128'd4);

        // Leaky ReLU and bypass leave the counter alone
        applyStimulus(packLanes(-8, -1, -3, 12), 2'd3, 0, 2, 1'b0);
        #1 checkOutput("leaky_data", out_data, packLanes(-2, -1, -1, 12));
        applyStimulus(packLanes(-100, 32'h7FFF_FFFF, 32'h8000_0000, 1), 2'd0, 0, 0, 1'b0);
        #1;
        checkOutput("bypass_data",  out_data, packLanes(-100, 32'h7FFF_FFFF, 32'h8000_0000, 1));
        checkOutput("bypass_count", {96'd0, zero_count}, 128'd4);

        // Config switch between back-to-back beats
        applyStimulus(packLanes(-5, -5, -5, -5), 2'd1, 0, 0, 1'b0);
        #1 checkOutput("switch_first", out_data, packLanes(0, 0, 0, 0));
        applyStimulus(packLanes(-5, -5, -5, -5), 2'd0, 0, 0, 1'b0);
        #1 checkOutput("switch_second", out_data, packLanes(-5, -5, -5, -5));
        idle(3);

        // Backpressure: ten beats against a stalled sink, then release
        out_ready = 1'b0;
        popsSeen  = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    applyStimulus(packLanes(k*16, k*16+1, k*16+2, k*16+3), 2'd0, 0, 0, 1'b0);
                end
            end
            begin
                repeat (8) @(negedge clk);
                checkOutput("bp_level", {126'd0, fifo_level}, 128'd2);
                checkOutput("bp_ready", {127'd0, in_ready},   128'd0);
                out_ready = 1'b1;
            end
        join
        idle(4);
        checkOutput("bp_delivered", 128'(popsSeen), 128'd10);

        // Counter saturation, then clear beating a same-cycle increment
        @(negedge clk);
        #1 force dut.zeroCount_q = 32'hFFFF_FFFE;
        zcModel = 64'hFFFF_FFFE;
        #1 release dut.zeroCount_q;
        applyStimulus(packLanes(-1, -2, -3, -4), 2'd1, 0, 0, 1'b0);
        #1 checkOutput("sat_count", {96'd0, zero_count}, {96'd0, 32'hFFFF_FFFF});
        applyStimulus(packLanes(-1, -1, 2, 2), 2'd2, 9, 0, 1'b1);
        #1 checkOutput("clr_count", {96'd0, zero_count}, 128'd0);
        applyStimulus(packLanes(-1, 5, 5, 5), 2'd1, 0, 0, 1'b0);
        #1 checkOutput("after_clr_count", {96'd0, zero_count}, 128'd1);
        idle(2);

        // Asynchronous reset with two beats buffered
        out_ready = 1'b0;
        applyStimulus(packLanes(1, 2, 3, 4), 2'd0, 0, 0, 1'b0);
        applyStimulus(packLanes(5, 6, 7, 8), 2'd0, 0, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("flush_valid", {127'd0, out_valid},  128'd0);
        checkOutput("flush_level", {126'd0, fifo_level}, 128'd0);
        checkOutput("flush_ready", {127'd0, in_ready},   128'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(4);
        checkOutput("post_flush_valid", {127'd0, out_valid}, 128'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
